// File: rtl/serial_frame_receiver.sv
// UART-style frame receiver (start 0, DATA_W bits LSB-first, stop 1) with a one-entry valid/ready output buffer.
// Define SERIAL_FRAME_PARITY_CHECK_EN to add an odd-parity bit between the data bits and the stop bit.
module serial_frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    ERR_WAIT
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift_reg, shift_n;
  logic [DATA_W-1:0] out_data_n;
  logic              out_valid_n;
  logic              frame_err_n;
  logic              overrun_n;
  logic              frame_good;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
  logic              parity_bit, parity_bit_n;
  logic              parity_err_q, parity_err_n;
`endif

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_reg;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    frame_good  = 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    parity_bit_n = parity_bit;
    parity_err_n = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (!in) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        shift_n   = {in, shift_reg[DATA_W-1:1]};
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      PARITY: begin
        parity_bit_n = in;
        state_n      = STOP;
      end
`endif
      STOP: begin
        if (in) begin
          state_n = IDLE;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
          if (^{shift_reg, parity_bit}) frame_good   = 1'b1;
          else                          parity_err_n = 1'b1;
`else
          frame_good = 1'b1;
`endif
        end else begin
          frame_err_n = 1'b1;
          state_n     = ERR_WAIT;
        end
      end
      ERR_WAIT: begin
        if (in) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A consumer handshake frees the slot, so a frame finishing on the same edge can take it.
    if (out_valid && out_ready) out_valid_n = 1'b0;
    if (frame_good) begin
      if (!out_valid || out_ready) begin
        out_data_n  = shift_reg;
        out_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      parity_bit   <= parity_bit_n;
      parity_err_q <= parity_err_n;
`endif
    end
  end

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: a frame-level buffer model queues expected
// deliveries and pulses; a negedge monitor pops and compares them against the DUT.
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;
  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_FERR = 2;
  localparam int EV_PERR = 3;

  logic              clk;
  logic              resetn;
  logic              in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  // model state: buffer occupancy/content, and the copy visible after the last edge
  logic              m_full = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic              exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;

  logic [DATA_W-1:0] data_q[$];
  int                ferr_q[$];
  int                ovr_q[$];
  int                perr_q[$];

  serial_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in         (in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 1) != 0);
  endfunction

  // Drive one bit-time; ev says what the bench intends the coming edge to complete.
  task automatic applyStimulus(input logic in_v, input logic rdy_v, input int ev,
                               input logic [DATA_W-1:0] data);
    in        = in_v;
    out_ready = rdy_v;
    resetn    = 1'b1;
    if (m_full && rdy_v) m_full = 1'b0;
    case (ev)
      EV_GOOD: begin
        if (!m_full) begin
          m_full = 1'b1;
          m_data = data;
          data_q.push_back(data);
        end else begin
          ovr_q.push_back(cyc + 1);
        end
      end
      EV_FERR: ferr_q.push_back(cyc + 1);
      EV_PERR: perr_q.push_back(cyc + 1);
      default: ;
    endcase
    @(posedge clk);
    #1;
    exp_valid = m_full;
    exp_data  = m_data;
  endtask

  task automatic applyReset(input int n);
    resetn    = 1'b0;
    in        = 1'b1;
    out_ready = 1'b0;
    m_full    = 1'b0;
    m_data    = '0;
    data_q.delete();
    ferr_q.delete();
    ovr_q.delete();
    perr_q.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    exp_valid = 1'b0;
    exp_data  = '0;
    resetn    = 1'b1;
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, pick_rdy(rdy_mode), EV_NONE, '0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input bit bad_stop, input bit bad_par,
                            input int rdy_mode, input bit stop_rdy, input int err_hold);
    logic par;
    applyStimulus(1'b0, pick_rdy(rdy_mode), EV_NONE, '0);
    for (int i = 0; i < DATA_W; i++) applyStimulus(data[i], pick_rdy(rdy_mode), EV_NONE, '0);
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    par = ~(^data) ^ bad_par;
    applyStimulus(par, pick_rdy(rdy_mode), EV_NONE, '0);
`else
    par = 1'b0;
`endif
    if (bad_stop) begin
      applyStimulus(1'b0, stop_rdy, EV_FERR, '0);
      for (int i = 0; i < err_hold; i++) applyStimulus(1'b0, pick_rdy(rdy_mode), EV_NONE, '0);
      applyStimulus(1'b1, pick_rdy(rdy_mode), EV_NONE, '0);
    end else if (bad_par && par == ~(^data)) begin
      applyStimulus(1'b1, stop_rdy, EV_GOOD, data);
    end else if (bad_par) begin
      applyStimulus(1'b1, stop_rdy, EV_PERR, '0);
    end else begin
      applyStimulus(1'b1, stop_rdy, EV_GOOD, data);
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    logic exp_p;
    logic [DATA_W-1:0] d;
    if (mon_en) begin
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("out_data", 32'(out_data), 32'(exp_data));
      exp_p = (ferr_q.size() != 0) && (ferr_q[0] == cyc);
      if (exp_p) void'(ferr_q.pop_front());
      checkOutput("frame_err", 32'(frame_err), 32'(exp_p));
      exp_p = (ovr_q.size() != 0) && (ovr_q[0] == cyc);
      if (exp_p) void'(ovr_q.pop_front());
      checkOutput("overrun", 32'(overrun), 32'(exp_p));
      exp_p = (perr_q.size() != 0) && (perr_q[0] == cyc);
      if (exp_p) void'(perr_q.pop_front());
      checkOutput("parity_err", 32'(parity_err), 32'(exp_p));
      if (resetn && out_valid && out_ready) begin
        if (data_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL handshake: got data %0h with nothing expected (cycle %0d)", out_data, cyc);
        end else begin
          d = data_q.pop_front();
          checkOutput("handshake_data", 32'(out_data), 32'(d));
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    bit bad_stop;
    bit bad_par;
    resetn    = 1'b0;
    in        = 1'b1;
    out_ready = 1'b0;

    $display("[TB] reset and idle");
    applyReset(2);
    mon_en = 1'b1;
    idle(5, 0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_data", 32'(out_data), 32'h0);

    $display("[TB] good frame A5");
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 0);
    checkOutput("a5_valid", 32'(out_valid), 32'h1);
    checkOutput("a5_data", 32'(out_data), 32'hA5);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);
    checkOutput("a5_consumed", 32'(out_valid), 32'h0);

    $display("[TB] framing error then 3C");
    send_frame(8'h77, 1'b1, 1'b0, 0, 1'b0, 2);
    checkOutput("ferr_no_valid", 32'(out_valid), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 0);
    checkOutput("3c_data", 32'(out_data), 32'h3C);
    idle(2, 1);

    $display("[TB] overrun");
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(1, 0);
    checkOutput("ovr_keeps_11", 32'(out_data), 32'h11);
    idle(2, 1);
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b1, 0);
    idle(1, 0);
    checkOutput("replace_22", 32'(out_data), 32'h22);
    idle(2, 1);

    $display("[TB] mid-frame reset");
    applyStimulus(1'b0, 1'b0, EV_NONE, '0);
    applyStimulus(1'b1, 1'b0, EV_NONE, '0);
    applyStimulus(1'b1, 1'b0, EV_NONE, '0);
    applyStimulus(1'b0, 1'b0, EV_NONE, '0);
    applyStimulus(1'b1, 1'b0, EV_NONE, '0);
    applyReset(1);
    idle(2, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0, 0);
    idle(1, 0);
    checkOutput("5a_data", 32'(out_data), 32'h5A);
    idle(2, 1);

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    $display("[TB] parity");
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 0);
    checkOutput("par_ok_data", 32'(out_data), 32'hA5);
    idle(2, 1);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 0);
    idle(1, 0);
    checkOutput("par_bad_no_valid", 32'(out_valid), 32'h0);
`endif

    $display("[TB] random frames");
    for (int n = 0; n < 150; n++) begin
      d        = DATA_W'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
      bad_par  = ($urandom_range(0, 7) == 0);
`else
      bad_par  = 1'b0;
`endif
      send_frame(d, bad_stop, bad_par, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 1) != 0), int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)), 2);
    end

    idle(5, 1);
    checkOutput("data_q_empty", 32'(data_q.size()), 32'h0);
    checkOutput("pulse_q_empty", 32'(ferr_q.size() + ovr_q.size() + perr_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Downstream consumer of the registered serial line produced by the single-bit D flip-flop stage; its `in` port is fed directly from that stage's `q`.
- Detects a UART-style frame on the bit stream: start bit 0, then DATA_W data bits LSB-first, then stop bit 1.
- Delivers each good byte through a one-entry valid/ready output buffer.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16)

Ports:
- clk  input  1  rising-edge clock, shared with the upstream flip-flop stage
- resetn  input  1  synchronous active-low reset, sampled on posedge clk
- in  input  1  serial bit stream; idle level 1
- out_data  output  DATA_W  last accepted frame payload; bit 0 = first data bit received
- out_valid  output  1  out_data holds an unconsumed frame
- out_ready  input  1  consumer accepts out_data on a posedge where out_valid && out_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: good frame dropped because buffer full
- parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset:
  - resetn==0 at posedge → state IDLE, bit counter 0, shift register 0.
  - out_data=0, out_valid=0, frame_err=0, overrun=0, parity_err=0.
  - Reset has priority over every other event.
  - A reset mid-frame discards the partial frame; reception restarts from IDLE.
- All outputs are registered; no combinational path from in or out_ready to any output.
- FSM states: IDLE, DATA, PARITY (only with macro), STOP, ERR_WAIT.
  - IDLE: in==0 → DATA, counter←0. in==1 → stay.
  - DATA: shift in one bit per cycle, LSB first. After DATA_W bits → PARITY if macro defined, else STOP.
  - STOP, in==1: frame good → IDLE. The same edge attempts to load the buffer.
  - STOP, in==0: frame_err pulses next cycle, frame discarded → ERR_WAIT.
  - ERR_WAIT: stay while in==0; in==1 → IDLE.
- Back-to-back frames: a start bit may appear in the cycle immediately after the stop bit, with no gap cycle.
- Latency: start sampled at edge E0, data at E1..E(DATA_W), stop at E(DATA_W+1) (one edge later with parity). out_valid is high after the stop-sampling edge.
- Buffer load rules at a good-frame edge:
  - out_valid==0 → load out_data, set out_valid.
  - out_valid==1 && out_ready==1 → old frame consumed, new frame loaded, out_valid stays 1.
  - out_valid==1 && out_ready==0 → new frame dropped, out_data unchanged, overrun pulses next cycle.
- Without a good frame: out_valid && out_ready at posedge → out_valid←0. out_data keeps its old value.
- out_ready while out_valid==0 is ignored.
- Pulse outputs are high for exactly one cycle per event; otherwise 0.

Optional Feature:
- Macro: SERIAL_FRAME_PARITY_CHECK_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; one odd-parity bit is sampled.
  - Odd parity: XOR of data bits and parity bit must be 1.
  - Mismatch with a valid stop bit: frame discarded, parity_err pulses, no buffer load, no overrun.
  - Mismatch with a bad stop bit: frame_err only.
- Undefined: no PARITY state, stop bit follows the last data bit, parity_err tied to 0.

Test Plan:
- Reset/idle: resetn=0 for 2 cycles, then in=1 for 5 cycles → all outputs 0, no out_valid.
- Good frame (no macro): in = 0, then 1,0,1,0,0,1,0,1, then 1; out_ready=0 → out_valid=1 with out_data=8'hA5 one edge after the stop bit. Value held until out_ready=1, then out_valid=0 the next cycle.
- Framing error: start, 8 data bits, then in=0 held 3 cycles, then 1 → frame_err one pulse, out_valid stays 0. A following 8'h3C frame is received correctly.
- Overrun: receive 8'h11 with out_ready=0, then back-to-back 8'h22 → overrun pulses once, out_data stays 8'h11. Repeat with out_ready=1 at the second frame's stop edge → out_data=8'h22, out_valid continuous, no overrun.
- Mid-frame reset: resetn=0 after 4 data bits, then a full 8'h5A frame → only 8'h5A delivered.
- Parity (macro defined): 8'hA5 with parity bit 1 → delivered. 8'hA5 with parity bit 0 → parity_err pulse, out_valid stays 0.
